// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive control path.
//   rx_ctrl_state_t : controller state encoding (OFF, IDLE, CAPTURE, HOLD, DRAIN)
//   FRAME_BITS      : bit times per character (start + 8 data + stop)
//   timeout_cnt_w() : width of the idle-timeout tick counter
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_IDLE    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_HOLD    = 3'd3,
    ST_DRAIN   = 3'd4
  } rx_ctrl_state_t;

  // The counter must be able to hold the terminal count itself (it saturates there).
  function automatic int timeout_cnt_w(input int chars, input int over_sample);
    return $clog2(chars * FRAME_BITS * over_sample + 1);
  endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// -----------------------------------------------------------------------------
// uart_rx_timeout
// Idle-timeout tick counter. Counts oversample ticks while enabled, clears on
// request, and saturates at TIMEOUT_CHARS character times.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_stick        : oversample tick
//   i_count_en     : count ticks this cycle (controller idle with FIFO data)
//   i_clr          : restart the count (capture, CPU read, FIFO empty)
//   o_hit          : single-cycle pulse on the tick that reaches the limit
// -----------------------------------------------------------------------------
module uart_rx_timeout
  import uart_pkg::*;
#(
  parameter int OVER_SAMPLE   = 16,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_stick,
  input  logic i_count_en,
  input  logic i_clr,
  output logic o_hit
);

  localparam int                 CNT_W   = timeout_cnt_w(TIMEOUT_CHARS, OVER_SAMPLE);
  localparam int                 LIMIT_I = TIMEOUT_CHARS * FRAME_BITS * OVER_SAMPLE;
  localparam logic [CNT_W-1:0]   LIMIT   = CNT_W'(LIMIT_I);
  localparam logic [CNT_W-1:0]   LAST    = CNT_W'(LIMIT_I - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             step;

  assign step  = i_count_en && i_stick && (cnt_q != LIMIT);
  // Pulse only on arrival so a cleared sticky flag is not immediately re-set
  // while the counter sits saturated.
  assign o_hit = !i_clr && step && (cnt_q == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else if (step) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Controller between the UART receiver and the RX FIFO / CPU registers.
// Enables the receiver, turns each receiver done level into a single FIFO
// write, flags overrun, and raises threshold and idle-timeout interrupts.
// Optional feature: define UART_RX_TIMEOUT_EN to build the idle-timeout
// interrupt; otherwise o_irq_timeout is tied low.
// Ports:
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_stick             : oversample tick from the baud generator
//   i_cfg_rx_en         : CPU receive enable
//   i_cfg_thresh        : FIFO level interrupt threshold (0 = disabled)
//   i_irq_clr           : clears sticky overrun / timeout flags
//   i_fifo_rd           : CPU FIFO read pulse
//   i_rx_data, i_rx_done: receiver data and multi-cycle done level
//   i_fifo_full, i_fifo_count : FIFO status
//   o_rx_en             : receiver start-detect enable
//   o_fifo_wr, o_fifo_wdata : FIFO write strobe and data
//   o_overrun, o_irq_thresh, o_irq_timeout, o_irq : interrupt flags
//   o_busy              : controller in CAPTURE, HOLD or DRAIN
// -----------------------------------------------------------------------------
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int SIZE_DATA     = 8,
  parameter int OVER_SAMPLE   = 16,
  parameter int SIZE_FIFO_CNT = 5,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_stick,
  input  logic                     i_cfg_rx_en,
  input  logic [SIZE_FIFO_CNT-1:0] i_cfg_thresh,
  input  logic                     i_irq_clr,
  input  logic                     i_fifo_rd,
  input  logic [SIZE_DATA-1:0]     i_rx_data,
  input  logic                     i_rx_done,
  input  logic                     i_fifo_full,
  input  logic [SIZE_FIFO_CNT-1:0] i_fifo_count,
  output logic                     o_rx_en,
  output logic                     o_fifo_wr,
  output logic [SIZE_DATA-1:0]     o_fifo_wdata,
  output logic                     o_overrun,
  output logic                     o_irq_thresh,
  output logic                     o_irq_timeout,
  output logic                     o_irq,
  output logic                     o_busy
);

  localparam int                   DRAIN_TICKS = FRAME_BITS * OVER_SAMPLE;
  localparam int                   DRAIN_W     = $clog2(DRAIN_TICKS);
  localparam logic [DRAIN_W-1:0]   DRAIN_LAST  = DRAIN_W'(DRAIN_TICKS - 1);

  rx_ctrl_state_t       state_q, state_d;
  logic                 done_q;
  logic                 rise;
  logic                 latch;
  logic                 capture;
  logic                 rx_en_q;
  logic [SIZE_DATA-1:0] wdata_q;
  logic                 overrun_q;
  logic                 thresh_q;
  logic                 timeout;
  logic [DRAIN_W-1:0]   drain_cnt_q;
  logic                 drain_expire;

  assign rise         = i_rx_done && !done_q;
  assign capture      = (state_q == ST_CAPTURE);
  assign drain_expire = i_stick && (drain_cnt_q == DRAIN_LAST);

  // Next-state logic. A rise takes priority over enable changes and drain
  // expiry so that a frame completing at the boundary is never lost.
  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    unique case (state_q)
      ST_OFF: begin
        if (i_cfg_rx_en) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (rise) begin
          latch   = 1'b1;
          state_d = ST_CAPTURE;
        end else if (!i_cfg_rx_en) begin
          state_d = ST_DRAIN;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!i_rx_done) state_d = i_cfg_rx_en ? ST_IDLE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (rise) begin
          latch   = 1'b1;
          state_d = ST_CAPTURE;
        end else if (i_cfg_rx_en) begin
          state_d = ST_IDLE;
        end else if (drain_expire) begin
          state_d = ST_OFF;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Control registers: state, edge detect, receiver enable
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_OFF;
      done_q  <= 1'b0;
      rx_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= i_rx_done;
      // Enable follows the destination state; CAPTURE/HOLD keep whatever the
      // entry path had, so a capture during DRAIN does not re-enable the receiver.
      if (state_d == ST_IDLE) begin
        rx_en_q <= 1'b1;
      end else if ((state_d == ST_OFF) || (state_d == ST_DRAIN)) begin
        rx_en_q <= 1'b0;
      end
    end
  end

  // Drain window: restarts every time DRAIN is entered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      drain_cnt_q <= '0;
    end else if (state_q != ST_DRAIN) begin
      drain_cnt_q <= '0;
    end else if (i_stick && (drain_cnt_q != DRAIN_LAST)) begin
      drain_cnt_q <= drain_cnt_q + 1'b1;
    end
  end

  // Captured byte and interrupt flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wdata_q   <= '0;
      overrun_q <= 1'b0;
      thresh_q  <= 1'b0;
    end else begin
      if (latch) wdata_q <= i_rx_data;
      // Set wins over a simultaneous clear.
      overrun_q <= (capture && i_fifo_full) || (overrun_q && !i_irq_clr);
      thresh_q  <= (state_q != ST_OFF) && (i_cfg_thresh != '0) &&
                   (i_fifo_count >= i_cfg_thresh);
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  logic timeout_q;
  logic timeout_hit;

  uart_rx_timeout #(
    .OVER_SAMPLE   (OVER_SAMPLE),
    .TIMEOUT_CHARS (TIMEOUT_CHARS)
  ) u_timeout (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_stick    (i_stick),
    .i_count_en ((state_q == ST_IDLE) && (i_fifo_count != '0)),
    .i_clr      (capture || i_fifo_rd || (i_fifo_count == '0)),
    .o_hit      (timeout_hit)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit || (timeout_q && !i_irq_clr && !capture);
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = i_fifo_rd ^ (TIMEOUT_CHARS != 0);
  assign timeout        = 1'b0;
`endif

  assign o_rx_en       = rx_en_q;
  // FIFO full is looked at only in the CAPTURE cycle.
  assign o_fifo_wr     = capture && !i_fifo_full;
  assign o_fifo_wdata  = wdata_q;
  assign o_overrun     = overrun_q;
  assign o_irq_thresh  = thresh_q;
  assign o_irq_timeout = timeout;
  assign o_irq         = overrun_q || thresh_q || timeout;
  assign o_busy        = (state_q == ST_CAPTURE) || (state_q == ST_HOLD) ||
                         (state_q == ST_DRAIN);

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Control block between the UART `Receiver` and the RX FIFO / CPU register interface. It enables the receiver and detects completed frames from its done level. Each captured byte is pushed into the FIFO as a single-cycle write, and the block flags overrun when the FIFO is full. It also generates threshold and idle-timeout interrupts toward the CPU.

## Interface
- `SIZE_DATA`, 8, data bits per frame (matches `Receiver`)
- `OVER_SAMPLE`, 16, `i_stick` ticks per bit
- `SIZE_FIFO_CNT`, 5, width of the FIFO occupancy count
- `TIMEOUT_CHARS`, 4, idle character times before the timeout interrupt (one character = 10 bits)
- `i_clk` in 1: single clock for all logic.
- `i_rst_n` in 1: asynchronous reset, active low.
- `i_stick` in 1: oversample tick from the baud generator.
- `i_cfg_rx_en` in 1: CPU receive enable.
- `i_cfg_thresh` in SIZE_FIFO_CNT: FIFO-level interrupt threshold; 0 disables it.
- `i_irq_clr` in 1: pulse that clears the sticky overrun and timeout flags.
- `i_fifo_rd` in 1: CPU FIFO read pulse.
- `i_rx_data` in SIZE_DATA: receiver parallel data.
- `i_rx_done` in 1: receiver done level, multi-cycle.
- `i_fifo_full` in 1: RX FIFO full.
- `i_fifo_count` in SIZE_FIFO_CNT: RX FIFO occupancy.
- `o_rx_en` out 1: receiver start-detect enable.
- `o_fifo_wr` out 1: FIFO write strobe.
- `o_fifo_wdata` out SIZE_DATA: FIFO write data.
- `o_overrun` out 1: sticky; a byte was dropped.
- `o_irq_thresh` out 1: FIFO level is at or above the threshold.
- `o_irq_timeout` out 1: sticky idle-timeout flag.
- `o_irq` out 1: OR of all three flags.
- `o_busy` out 1: controller is in the CAPTURE, HOLD or DRAIN state.

## Operation
- States: OFF, IDLE, CAPTURE, HOLD, DRAIN. The reset state is OFF.
- Rising-edge detect on `i_rx_done`: rise = `i_rx_done` & ~done_q. done_q resets to 0 and updates every cycle.
- OFF:
  - `o_rx_en`=0 and rises are ignored.
  - Goes to IDLE when `i_cfg_rx_en`=1.
- IDLE:
  - `o_rx_en`=1.
  - On a rise, latch `i_rx_data` into `o_fifo_wdata` and go to CAPTURE.
  - If `i_cfg_rx_en`=0 (and no rise this cycle), go to DRAIN.
- CAPTURE (exactly one cycle):
  - If `i_fifo_full`=0, `o_fifo_wr`=1.
  - Otherwise `o_fifo_wr`=0 and `o_overrun` is set.
  - Next state is HOLD.
- HOLD: waits for `i_rx_done`=0, then goes to IDLE, or to DRAIN if `i_cfg_rx_en`=0.
- DRAIN:
  - `o_rx_en`=0. A frame already in flight may still complete.
  - A drain counter counts `i_stick` ticks up to 10*`OVER_SAMPLE`-1.
  - A rise before expiry latches data and goes to CAPTURE. The controller then returns via HOLD and re-evaluates enable.
  - On expiry, go to OFF.
  - If `i_cfg_rx_en` returns to 1 before expiry, go to IDLE.
- Threshold: `o_irq_thresh` is registered `i_cfg_thresh`!=0 && `i_fifo_count` >= `i_cfg_thresh`, and is 0 in OFF. Comparison is unsigned, at full width.
- Sticky flags: the clear takes effect the cycle after `i_irq_clr`. If a set and a clear happen in the same cycle, set wins.

## Timing
- Reset values: every output is 0, including `o_fifo_wdata`. The state is OFF.
- Enable latency: `o_rx_en` goes high 1 cycle after `i_cfg_rx_en` rises while in OFF.
- Write latency: a rise at cycle N gives `o_fifo_wr`=1 at cycle N+1. `o_fifo_wdata` equals `i_rx_data` as sampled at cycle N and holds until the next capture.
- At most one write per `i_rx_done` high period, whatever its length.
- `i_fifo_full` is sampled in the CAPTURE cycle only.
- `o_irq` is combinational from the registered flags.
- Reset asserted mid-operation clears everything immediately, with no pending write.

## Configuration
- `UART_RX_TIMEOUT_EN` defined:
  - An idle counter counts `i_stick` ticks while in IDLE with `i_fifo_count`!=0.
  - It clears on CAPTURE, on `i_fifo_rd`, or when the FIFO is empty.
  - When it reaches `TIMEOUT_CHARS`*10*`OVER_SAMPLE` ticks, it sets `o_irq_timeout` (sticky) and saturates.
  - `o_irq_timeout` also clears on the next CAPTURE.
- Not defined: `o_irq_timeout` is tied to 0 and no counter logic exists.

## Structure
- `uart_pkg` holds:
  - the enum typedef `rx_ctrl_state_t`
  - the constant `FRAME_BITS`=10
  - the function computing the timeout counter width with `$clog2`
- Sub-module `uart_rx_timeout`: the tick counter plus compare, instantiated only under `UART_RX_TIMEOUT_EN`. The DRAIN counter is local to the controller.

## Test plan
- Enable, one byte: set `i_cfg_rx_en`=1, then drive `i_rx_done` high for 16 cycles with `i_rx_data`=8'hA5. Expect exactly one `o_fifo_wr` pulse, 1 cycle after the rise, with `o_fifo_wdata`=8'hA5.
- Overrun: with `i_fifo_full`=1, complete byte 8'h3C. Expect no `o_fifo_wr`, and `o_overrun`=1 and `o_irq`=1 until `i_irq_clr`. Pulse `i_irq_clr` in the same cycle as a second overrun: `o_overrun` stays 1.
- Threshold: `i_cfg_thresh`=4 and `i_fifo_count` steps 3→4→3. `o_irq_thresh` follows 0→1→0 with 1-cycle lag. With `i_cfg_thresh`=0, the flag stays 0.
- Timeout (macro on, `OVER_SAMPLE`=16, `TIMEOUT_CHARS`=4): with `i_fifo_count`=1 and no traffic, `o_irq_timeout` rises after exactly 640 ticks. With `i_fifo_rd` pulsed at tick 600, it rises at tick 1240 instead.
- Disable mid-frame: drop `i_cfg_rx_en` at cycle T, then a rise follows at tick 80. Expect `o_rx_en`=0 at T+1, the byte is still written, and the controller returns to OFF after 160 further ticks.
- Reset mid-CAPTURE: assert `i_rst_n`=0 during CAPTURE. No write occurs, all outputs are 0 and the state is OFF.
